// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, losing loads wait in a
// small FIFO, a pending-write scoreboard raises stall, and halt drains the queue.
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_vld,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_vld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_rdy,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              re0,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re1,
  output logic              stall,
  input  logic              hlt_in,
  output logic              we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst,
  output logic              hlt,
  output logic              ovf
);
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [QDEPTH-1:0]   qv_q, qv_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0]   dst_q, dst_d;
  logic                ovf_q, ovf_d;

  logic [ADDR_W-1:0]   qa_mem [QDEPTH];
  logic [DATA_W-1:0]   qd_mem [QDEPTH];
  logic [QDEPTH-1:0]   squash_hit;
  logic [NREG-1:0]     pend;

  logic active, full, empty, alu_ok, ld_take, pop, bypass, push;

  always_comb begin
    active  = (state_q != HALTED);
    full    = (cnt_q == (PW+1)'(QDEPTH));
    empty   = (cnt_q == '0);
    ld_rdy  = active & ~full;
    alu_ok  = active & alu_vld & (|alu_addr);
    // A load to the same register as a concurrent ALU write is older, so it is dropped.
    ld_take = active & ld_vld & ld_rdy & (|ld_addr) & ~(alu_ok & (ld_addr == alu_addr));
    pop     = active & ~alu_ok & ~empty;
    bypass  = active & ~alu_ok & empty & ld_take;
    push    = ld_take & ~bypass;
  end

  // Payload storage has no reset; the valid bits alone say what is live.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_q
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PW'(gi))) begin
        qa_mem[gi] <= ld_addr;
        qd_mem[gi] <= ld_data;
      end
    end
    assign squash_hit[gi] = alu_ok & (qa_mem[gi] == alu_addr);
  end

  always_comb begin
    we_d       = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_d      = dst_q;
    qv_d       = qv_q & ~squash_hit;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    ovf_d      = ovf_q | (active & ld_vld & ~ld_rdy);
    state_d    = state_q;

    if (alu_ok) begin
      we_d       = 1'b1;
      dst_addr_d = alu_addr;
      dst_d      = alu_data;
    end else if (pop) begin
      // A squashed head still consumes its slot but produces no write.
      we_d = qv_q[rd_ptr_q];
      if (qv_q[rd_ptr_q]) begin
        dst_addr_d = qa_mem[rd_ptr_q];
        dst_d      = qd_mem[rd_ptr_q];
      end
      qv_d[rd_ptr_q] = 1'b0;
      rd_ptr_d       = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      we_d       = 1'b1;
      dst_addr_d = ld_addr;
      dst_d      = ld_data;
    end

    if (push) begin
      qv_d[wr_ptr_q] = 1'b1;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end

    case (state_q)
      RUN:     if (hlt_in) state_d = DRAIN;
      DRAIN:   if (empty && !we_d && !alu_vld && !ld_vld) state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (qv_q[i]) pend[qa_mem[i]] = 1'b1;
    end
    if (we_q) pend[dst_addr_q] = 1'b1;
  end

  assign stall = active & ((re0 & pend[p0_addr] & (|p0_addr)) |
                           (re1 & pend[p1_addr] & (|p1_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      qv_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      dst_addr_q <= '0;
      dst_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      qv_q       <= qv_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      dst_addr_q <= dst_addr_d;
      dst_q      <= dst_d;
      ovf_q      <= ovf_d;
    end
  end

  assign we       = we_q;
  assign dst_addr = dst_addr_q;
  assign dst      = dst_q;
  assign hlt      = (state_q == HALTED);
  assign ovf      = ovf_q;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the register file's single write port (we/dst_addr/dst) and shares it between two writers: the ALU result path and the load-return path from data memory.
- Loads that lose arbitration wait in a small FIFO.
- A pending-write scoreboard stalls decode when it reads a register that still has a write outstanding.
- Sequences halt: drains outstanding writes, then reports the core halted.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (2**ADDR_W registers)
- QDEPTH, 2, load FIFO depth (power of two, at least 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_vld  in  1  ALU writeback valid; never back-pressured
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_vld  in  1  load-return valid
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_rdy  out  1  load path can accept this cycle
- p0_addr  in  ADDR_W  decoder read port 0 address
- re0  in  1  read port 0 enable
- p1_addr  in  ADDR_W  decoder read port 1 address
- re1  in  1  read port 1 enable
- stall  out  1  decode must hold (RAW hazard on a pending write)
- hlt_in  in  1  halt instruction decoded
- we  out  1  register-file write enable (registered)
- dst_addr  out  ADDR_W  register-file write address (registered)
- dst  out  DATA_W  register-file write data (registered)
- hlt  out  1  drain complete; core halted (sticky)
- ovf  out  1  sticky error: load arrived while ld_rdy=0

Behaviour:

Reset:
- Asynchronous on rst.
- we=0, dst_addr=0, dst=0, hlt=0, ovf=0.
- FIFO empty, state RUN.
- ld_rdy=1 and stall=0 once rst deasserts.

Register 0:
- R0 reads as zero in the register file.
- Writes to address 0 from either source are discarded: not issued, not enqueued, not pending.

Arbitration, evaluated each cycle in RUN or DRAIN:
- Priority 1: alu_vld issues the ALU write.
- Priority 2: otherwise, a non-empty FIFO issues its head.
- Priority 3: otherwise, a load with ld_vld issues directly (bypass, no enqueue).
- A load that does not issue enqueues, provided ld_rdy=1.
- Issued write appears on we/dst_addr/dst at the next rising edge, i.e. 1-cycle latency.
- we is high for exactly one cycle per issued write.

FIFO:
- ld_rdy = FIFO not full, in RUN and DRAIN; 0 in HALTED.
- Full with pop and push in the same cycle: ld_rdy stays 0 that cycle; no simultaneous push/pop while full.
- Pointers wrap modulo QDEPTH.

WAW ordering (ALU write is younger than any queued or arriving load):
- When alu_vld=1, every queued entry with addr==alu_addr is squashed (invalidated in place, skipped on pop, no write).
- An arriving ld_vld with ld_addr==alu_addr in the same cycle is dropped. It counts as accepted, so ovf does not set.

Scoreboard:
- pending[r] = 1 if any valid FIFO entry targets r, OR (we=1 and dst_addr==r).
- stall = (re0 & pending[p0_addr] & p0_addr!=0) | (re1 & pending[p1_addr] & p1_addr!=0).
- Combinational from registered state only; no path from ld_vld/alu_vld to stall.

Overflow:
- ld_vld=1 while ld_rdy=0 sets ovf.
- The load is dropped.
- ovf holds until reset.

State machine:
- RUN -> DRAIN when hlt_in=1.
- DRAIN: arbitration continues; hlt_in ignored.
- DRAIN -> HALTED when the FIFO is empty, no write issues this cycle, alu_vld=0 and ld_vld=0.
- HALTED: hlt=1 from the cycle after entry; we=0; all inputs ignored; ld_rdy=0; stall=0. Left only by reset.
- hlt_in with an empty FIFO and idle inputs: RUN -> DRAIN -> HALTED, so hlt rises 2 cycles after hlt_in.

Reset mid-operation: FIFO contents, pending state and halt state are cleared immediately; in-flight writes are lost.

Test Plan:
- Basic write: alu_vld=1, addr=3, data=0x1234, one cycle -> next edge we=1, dst_addr=3, dst=0x1234 for 1 cycle; ld_rdy stays 1.
- Collision: alu_vld (r2=0xAAAA) and ld_vld (r5=0x5555) in the same cycle -> r2 written cycle+1, r5 written cycle+2. With re0=1, p0_addr=5 during cycle+1, stall=1; cycle+3 stall=0.
- Full FIFO: alu_vld held high 4 cycles while loads to r4, r6, r7 arrive on consecutive cycles (QDEPTH=2) -> r4 and r6 enqueued, ld_rdy=0 on the third cycle, r7 dropped, ovf=1. After the ALU stops, r4 then r6 are written in order.
- WAW squash: load r9=0x0001 queued behind ALU traffic, then alu_vld r9=0x0002 -> only one r9 write (0x0002); the FIFO entry is skipped with no we pulse.
- R0 discard: alu_vld addr=0 and ld_vld addr=0 -> no we; pending stays 0; re0=1 with p0_addr=0 never stalls.
- Halt: two loads queued, hlt_in pulsed -> both writes complete, hlt=1 the cycle after the last we, ld_rdy=0 afterwards. A further alu_vld produces no we. Asserting rst mid-drain clears hlt, we and the FIFO immediately.
